pixel_array_ctrl: RTL

//  Digital controller on the far side of the 2x2 pixel array's control pins and shared DATA buses.

---
 rtl/pixel_ctrl_pkg.sv | 32 +++
 rtl/pixel_array_ctrl_adc_counter.sv | 31 +++
 rtl/pixel_array_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the 2x2 pixel array controller: frame state
// encoding, default sizes and binary/Gray conversion.
package pixel_ctrl_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int NUM_PIX_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        TURN,
        READ,
        STREAM
    } state_t;

    // Helpers work on 32 bits; callers truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_array_ctrl_adc_counter.sv
// Saturating ramp counter for the single-slope conversion; exposes the binary
// value, its Gray code and a flag once the top code is reached.
module adc_counter
    import pixel_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [DATA_W-1:0] o_bin,
    output logic [DATA_W-1:0] o_gray,
    output logic              o_done
);

    logic [DATA_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bin  = r_cnt;
    assign o_gray = DATA_W'(bin2gray(32'(r_cnt)));
    assign o_done = &r_cnt;

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: ERASE -> EXPOSE -> CONVERT -> TURN
// -> READ, then streams the captured pixels. Define PIXEL_GRAY_COUNT_EN to put
// a Gray-coded ramp count on the DATA buses (samples are decoded on capture).
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int NUM_PIX       = NUM_PIX_DEF,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    parameter int READ_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      erase,
    output logic                      expose,
    output logic                      ramp_en,
    output logic                      read,
    output logic [NUM_PIX*DATA_W-1:0] bus_out,
    output logic                      bus_oe,
    input  logic [NUM_PIX*DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0]         pix_data,
    output logic [1:0]                pix_idx,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic                      frame_done
);

`ifdef PIXEL_GRAY_COUNT_EN
    localparam bit USE_GRAY = 1'b1;
`else
    localparam bit USE_GRAY = 1'b0;
`endif

    localparam int MAX_AB = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int MAX_C  = (MAX_AB > READ_CYCLES) ? MAX_AB : READ_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    state_t                          r_state, w_next;
    logic [CNT_W-1:0]                r_cnt;
    logic [1:0]                      r_idx;
    logic [NUM_PIX-1:0][DATA_W-1:0]  r_buf;
    logic                            w_phase_last;
    logic                            w_timed;
    logic                            w_last_pix;
    logic [DATA_W-1:0]               w_bin, w_gray, w_bus_val;
    logic                            w_adc_done;
    logic [NUM_PIX-1:0][DATA_W-1:0]  w_sample;

    adc_counter #(.DATA_W(DATA_W)) u_adc (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (r_state != CONVERT),
        .i_en   (r_state == CONVERT),
        .o_bin  (w_bin),
        .o_gray (w_gray),
        .o_done (w_adc_done)
    );

    assign w_bus_val  = USE_GRAY ? w_gray : w_bin;
    assign w_last_pix = (r_idx == 2'(NUM_PIX - 1));

    always_comb begin
        w_timed      = 1'b1;
        w_phase_last = 1'b0;
        case (r_state)
            ERASE:   w_phase_last = (r_cnt == CNT_W'(ERASE_CYCLES - 1));
            EXPOSE:  w_phase_last = (r_cnt == CNT_W'(EXPOSE_CYCLES - 1));
            READ:    w_phase_last = (r_cnt == CNT_W'(READ_CYCLES - 1));
            default: w_timed      = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)                   w_next = ERASE;
            ERASE:   if (w_phase_last)            w_next = EXPOSE;
            EXPOSE:  if (w_phase_last)            w_next = CONVERT;
            CONVERT: if (w_adc_done)              w_next = TURN;
            TURN:                                 w_next = READ;
            READ:    if (w_phase_last)            w_next = STREAM;
            STREAM:  if (pix_ready && w_last_pix) w_next = IDLE;
            default:                              w_next = IDLE;
        endcase
    end

    // Pads show the raw bus code; decode Gray before it reaches the buffer.
    always_comb begin
        for (int i = 0; i < NUM_PIX; i++) begin
            w_sample[i] = USE_GRAY ? DATA_W'(gray2bin(32'(bus_in[i*DATA_W +: DATA_W])))
                                   : bus_in[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || !w_timed) ? '0 : r_cnt + 1'b1;
            if (r_state == READ && w_phase_last) begin
                r_buf <= w_sample;
            end
            if (r_state == STREAM && pix_ready) begin
                r_idx <= w_last_pix ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign erase      = (r_state == ERASE);
    assign expose     = (r_state == EXPOSE);
    assign ramp_en    = (r_state == CONVERT);
    assign read       = (r_state == READ);
    assign bus_oe     = (r_state == CONVERT);
    assign bus_out    = bus_oe ? {NUM_PIX{w_bus_val}} : '0;
    assign pix_valid  = (r_state == STREAM);
    assign pix_data   = pix_valid ? r_buf[r_idx] : '0;
    assign pix_idx    = pix_valid ? r_idx : '0;
    assign frame_done = pix_valid && pix_ready && w_last_pix;

endmodule
